// File: rtl/dotmatrix_pkg.sv
// Shared definitions for the dot-matrix scan controller: register map,
// CTRL bit positions and the scan FSM state encoding.
package dotmatrix_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h80;
    localparam logic [7:0] ADDR_DISP   = 8'h81;
    localparam logic [7:0] ADDR_BLANK  = 8'h82;
    localparam logic [7:0] ADDR_BRIGHT = 8'h83;
    localparam logic [7:0] ADDR_STATUS = 8'h84;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SWAP_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DISP  = 2'd2,
        NEXT  = 2'd3
    } state_t;

endpackage

// File: rtl/dotmatrix_tick_gen.sv
// Fixed-ratio divider: one-cycle tick every TICK_DIV clocks, counting 0..TICK_DIV-1.
module dotmatrix_tick_gen #(
    parameter int TICK_DIV = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // wrap the counter on the last count so the period is exactly TICK_DIV
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/dotmatrix_scan_ctrl.sv
// Double-buffered LED dot-matrix scanner with bus-programmable timing and PWM brightness.
//
//  state | meaning
//  IDLE  | scanning disabled, outputs dark, row held at 0
//  BLANK | all rows off for BLANK_TIME ticks (ghosting guard)
//  DISP  | current row driven for max(DISP_TIME,1) ticks
//  NEXT  | one-cycle row advance; frame wrap and buffer swap happen here
module dotmatrix_scan_ctrl
    import dotmatrix_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int TICK_DIV  = 2500,
    parameter int DISP_RST  = 100,
    parameter int BLANK_RST = 10
) (
    input  logic            mclock,
    input  logic            mreset,
    input  logic            CS,
    input  logic            Write,
    input  logic            Read,
    input  logic [7:0]      Address,
    input  logic [7:0]      Data_i,
    input  logic [3:0]      STRB,
    output logic [7:0]      Data_o,
    output logic            ack,
    output logic [ROWS-1:0] Row,
    output logic [COLS-1:0] Col,
    output logic            frame_sync
);

    localparam int RW = $clog2(ROWS);

    logic [COLS-1:0] r_buf0 [ROWS];
    logic [COLS-1:0] r_buf1 [ROWS];
    logic            r_front_sel;
    logic            r_en;
    logic            r_swap_pending;
    logic [7:0]      r_disp_time;
    logic [7:0]      r_blank_time;
    logic [7:0]      r_bright;
    logic [7:0]      r_pwm_cnt;
    logic [7:0]      r_wait;
    logic [RW-1:0]   r_row;
    state_t          r_state;
    state_t          w_state_nxt;

    logic            w_tick;
    logic            w_acc;
    logic            w_wr;
    logic            w_rd;
    logic            w_row_addr;
    logic [RW-1:0]   w_addr_row;
    logic            w_last_row;
    logic            w_flip;
    logic            w_wait_done;
    logic [COLS-1:0] w_front_row;
    logic [COLS-1:0] w_back_rd;
    logic [7:0]      w_rd_data;
    logic            w_unused_strb;

    dotmatrix_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (mclock),
        .i_rst  (mreset),
        .o_tick (w_tick)
    );

    // only the low byte lane exists on this block
    assign w_unused_strb = ^STRB[3:1];

    assign w_acc       = CS & (Write | Read);
    assign w_wr        = CS & Write & STRB[0];
    assign w_rd        = CS & Read & ~Write;
    assign w_row_addr  = (Address < 8'(ROWS));
    assign w_addr_row  = Address[RW-1:0];
    assign w_last_row  = (r_row == RW'(ROWS - 1));
    assign w_flip      = (r_state == NEXT) && w_last_row && r_swap_pending;
    assign frame_sync  = (r_state == NEXT) && w_last_row;
    assign w_wait_done = (r_wait == 8'd0) || (w_tick && (r_wait == 8'd1));
    assign w_front_row = r_front_sel ? r_buf1[r_row] : r_buf0[r_row];
    assign w_back_rd   = r_front_sel ? r_buf0[w_addr_row] : r_buf1[w_addr_row];

    // read data mux; unmapped addresses return zero
    always_comb begin
        w_rd_data = 8'h00;
        if (w_row_addr)
            w_rd_data = 8'(w_back_rd);
        else if (Address == ADDR_CTRL)
            w_rd_data = {6'b0, r_swap_pending, r_en};
        else if (Address == ADDR_DISP)
            w_rd_data = r_disp_time;
        else if (Address == ADDR_BLANK)
            w_rd_data = r_blank_time;
        else if (Address == ADDR_BRIGHT)
            w_rd_data = r_bright;
        else if (Address == ADDR_STATUS)
            w_rd_data = {3'b0, (r_state == DISP), 4'(r_row)};
    end

    // bus response: every access acked one cycle later, data only for pure reads
    always_ff @(posedge mclock or posedge mreset) begin
        if (mreset) begin
            ack    <= 1'b0;
            Data_o <= 8'h00;
        end else begin
            ack    <= w_acc;
            Data_o <= w_rd ? w_rd_data : 8'h00;
        end
    end

    // control registers; a pending swap is consumed at the frame wrap, so a
    // SWAP write landing on that same edge is absorbed by the swap it already requested
    always_ff @(posedge mclock or posedge mreset) begin
        if (mreset) begin
            r_en           <= 1'b1;
            r_swap_pending <= 1'b0;
            r_front_sel    <= 1'b0;
            r_disp_time    <= 8'(DISP_RST);
            r_blank_time   <= 8'(BLANK_RST);
            r_bright       <= 8'hFF;
        end else begin
            if (w_flip) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
            end else if (w_wr && (Address == ADDR_CTRL) && Data_i[CTRL_SWAP_BIT]) begin
                r_swap_pending <= 1'b1;
            end
            if (w_wr) begin
                case (Address)
                    ADDR_CTRL:   r_en         <= Data_i[CTRL_EN_BIT];
                    ADDR_DISP:   r_disp_time  <= Data_i;
                    ADDR_BLANK:  r_blank_time <= Data_i;
                    ADDR_BRIGHT: r_bright     <= Data_i;
                    default:     ;
                endcase
            end
        end
    end

    // bus writes always land in the back buffer
    always_ff @(posedge mclock or posedge mreset) begin
        if (mreset) begin
            for (int i = 0; i < ROWS; i++) begin
                r_buf0[i] <= '0;
                r_buf1[i] <= '0;
            end
        end else if (w_wr && w_row_addr) begin
            if (r_front_sel)
                r_buf0[w_addr_row] <= Data_i[COLS-1:0];
            else
                r_buf1[w_addr_row] <= Data_i[COLS-1:0];
        end
    end

    // free-running PWM phase
    always_ff @(posedge mclock or posedge mreset) begin
        if (mreset)
            r_pwm_cnt <= 8'h00;
        else
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end

    // next-state decode; disable overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!r_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = BLANK;
                BLANK:   if (w_wait_done) w_state_nxt = DISP;
                DISP:    if (w_wait_done) w_state_nxt = NEXT;
                NEXT:    w_state_nxt = BLANK;
                default: w_state_nxt = BLANK;
            endcase
        end
    end

    // state, row and wait counter; timing registers are sampled only on state entry
    always_ff @(posedge mclock or posedge mreset) begin
        if (mreset) begin
            r_state <= BLANK;
            r_row   <= '0;
            r_wait  <= 8'(BLANK_RST);
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    BLANK:   r_wait <= r_blank_time;
                    DISP:    r_wait <= (r_disp_time == 8'd0) ? 8'd1 : r_disp_time;
                    default: r_wait <= 8'd0;
                endcase
            end else if (w_tick && (r_wait != 8'd0)) begin
                r_wait <= r_wait - 8'd1;
            end
            if (w_state_nxt == IDLE)
                r_row <= '0;
            else if (r_state == NEXT)
                r_row <= w_last_row ? '0 : r_row + 1'b1;
        end
    end

    // pin drive decoded from registered state only
    always_comb begin
        Row = '0;
        Col = '0;
        if (r_state == DISP) begin
            Row[r_row] = 1'b1;
            if (r_pwm_cnt < r_bright)
                Col = w_front_row;
        end
    end

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Directed bench for dotmatrix_scan_ctrl with a fast tick (TICK_DIV=4).
module tb_dotmatrix_scan_ctrl;

    logic       mclock = 1'b0;
    logic       mreset = 1'b1;
    logic       CS = 1'b0;
    logic       Write = 1'b0;
    logic       Read = 1'b0;
    logic [7:0] Address = 8'h00;
    logic [7:0] Data_i = 8'h00;
    logic [3:0] STRB = 4'h0;
    logic [7:0] Data_o;
    logic       ack;
    logic [7:0] Row;
    logic [7:0] Col;
    logic       frame_sync;

    int n_cmp = 0;
    int n_bad = 0;

    dotmatrix_scan_ctrl #(
        .ROWS(8), .COLS(8), .TICK_DIV(4), .DISP_RST(100), .BLANK_RST(10)
    ) dut (
        .mclock(mclock), .mreset(mreset), .CS(CS), .Write(Write), .Read(Read),
        .Address(Address), .Data_i(Data_i), .STRB(STRB), .Data_o(Data_o),
        .ack(ack), .Row(Row), .Col(Col), .frame_sync(frame_sync)
    );

    always #5 mclock = ~mclock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one bus cycle at a negedge; return ack/data of the next cycle and ack one later
    task automatic bus(input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [7:0] data, input logic [3:0] strb,
                       output logic [7:0] dout, output logic ak, output logic ak2);
        CS = 1'b1; Write = wr; Read = rd; Address = addr; Data_i = data; STRB = strb;
        @(negedge mclock);
        dout = Data_o; ak = ack;
        CS = 1'b0; Write = 1'b0; Read = 1'b0; STRB = 4'h0;
        @(negedge mclock);
        ak2 = ack;
    endtask

    task automatic do_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d; logic a, a2;
        bus(1'b0, 1'b1, addr, 8'h00, 4'h1, d, a, a2);
        check_val({tag, "_ack"}, a, 1);
        check_val({tag, "_data"}, d, exp);
        check_val({tag, "_ack1cyc"}, a2, 0);
    endtask

    task automatic do_wr(input string tag, input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] d; logic a, a2;
        bus(1'b1, 1'b0, addr, data, 4'h1, d, a, a2);
        check_val({tag, "_wack"}, a, 1);
    endtask

    // want==0 means any lit row
    task automatic wait_row(input string tag, input logic [7:0] want, input int lim);
        int k = 0;
        while (((want == 8'h00) ? (Row == 8'h00) : (Row != want)) && k < lim) begin
            @(negedge mclock);
            k++;
        end
        if (k >= lim) check_val({tag, "_timeout"}, 1, 0);
    endtask

    task automatic wait_fs(input string tag, input int lim);
        int k = 0;
        while (!frame_sync && k < lim) begin
            @(negedge mclock);
            k++;
        end
        check_val({tag, "_fs_seen"}, frame_sync, 1);
    endtask

    initial begin
        int bad, cnt, n, len;
        logic [7:0] seq [8];
        logic [7:0] acc, prev, e, d;
        logic a, a2;

        // 1: reset values and first blank interval
        repeat (2) @(negedge mclock);
        check_val("rst_row", Row, 0);
        check_val("rst_col", Col, 0);
        check_val("rst_ack", ack, 0);
        check_val("rst_dout", Data_o, 0);
        check_val("rst_fs", frame_sync, 0);
        mreset = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (Row != 8'h00) bad++;
            @(negedge mclock);
        end
        check_val("blank40_dark", bad, 0);
        check_val("first_disp_row", Row, 8'h01);
        do_rd("rd_disp", 8'h81, 8'd100);
        do_rd("rd_blank", 8'h82, 8'd10);
        do_rd("rd_bright", 8'h83, 8'hFF);

        // 2: back buffer write is invisible until swap
        do_wr("wr_back0", 8'h00, 8'hA5);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (Col != 8'h00) bad++;
            @(negedge mclock);
        end
        check_val("noswap_col_dark", bad, 0);
        do_rd("rd_back0", 8'h00, 8'hA5);
        do_wr("wr_swap", 8'h80, 8'h03);
        do_rd("rd_ctrl_pend", 8'h80, 8'h03);
        wait_fs("swap1", 8000);
        @(negedge mclock);
        do_rd("rd_ctrl_after", 8'h80, 8'h01);
        do_rd("rd_oldfront", 8'h00, 8'h00);
        wait_row("swap1_row0", 8'h01, 200);
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            acc |= Col;
            @(negedge mclock);
        end
        check_val("swap1_col", acc, 8'hA5);

        // 3: brightness duty
        do_wr("wr_back0_ff", 8'h00, 8'hFF);
        do_wr("wr_swap2", 8'h80, 8'h03);
        wait_fs("swap2", 8000);
        @(negedge mclock);
        do_wr("wr_bright40", 8'h83, 8'h40);
        wait_row("pwm_row0", 8'h01, 200);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            if (Col == 8'hFF) cnt++;
            @(negedge mclock);
        end
        check_val("pwm40_on_cycles", cnt, 64);
        do_wr("wr_bright0", 8'h83, 8'h00);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (Col != 8'h00) bad++;
            @(negedge mclock);
        end
        check_val("pwm0_dark", bad, 0);
        do_wr("wr_brightff", 8'h83, 8'hFF);

        // 4: minimum timing, full row sequence
        do_wr("wr_blank0", 8'h82, 8'h00);
        do_wr("wr_disp0", 8'h81, 8'h00);
        wait_fs("fast", 8000);
        n = 0; prev = 8'h00; len = 0; bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge mclock);
            if (frame_sync) break;
            if (Row != 8'h00) begin
                if (prev == 8'h00) begin
                    if (n < 8) seq[n] = Row;
                    n++;
                end
                len++;
            end else if (prev != 8'h00) begin
                if (len < 1 || len > 4) bad++;
                len = 0;
            end
            prev = Row;
        end
        check_val("fast_fs_again", frame_sync, 1);
        check_val("fast_rows_per_frame", n, 8);
        check_val("fast_disp_len", bad, 0);
        for (int i = 0; i < 8; i++) begin
            e = 8'd1 << i;
            check_val($sformatf("fast_seq%0d", i), (i < n) ? seq[i] : 8'h00, e);
        end
        wait_row("fast_wrap", 8'h00, 20);
        check_val("fast_wrap_row", Row, 8'h01);

        // 5: disable mid-DISP on row 3, then resume
        do_wr("wr_disp5", 8'h81, 8'h05);
        wait_row("row3", 8'h08, 500);
        do_rd("rd_status_disp", 8'h84, 8'h13);
        do_wr("wr_en0", 8'h80, 8'h00);
        check_val("idle_row", Row, 0);
        check_val("idle_col", Col, 0);
        do_rd("rd_status_idle", 8'h84, 8'h00);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (Row != 8'h00) bad++;
            @(negedge mclock);
        end
        check_val("idle_stays_dark", bad, 0);
        do_wr("wr_en1", 8'h80, 8'h01);
        wait_row("resume", 8'h00, 100);
        check_val("resume_row0", Row, 8'h01);

        // 6: async reset mid-DISP with a read in flight
        wait_row("pre_rst", 8'h00, 200);
        CS = 1'b1; Read = 1'b1; Address = 8'h81; STRB = 4'h1;
        @(posedge mclock);
        #2;
        check_val("prerst_ack", ack, 1);
        check_val("prerst_dout", Data_o, 8'd5);
        mreset = 1'b1;
        #1;
        check_val("arst_row", Row, 0);
        check_val("arst_col", Col, 0);
        check_val("arst_ack", ack, 0);
        check_val("arst_dout", Data_o, 0);
        check_val("arst_fs", frame_sync, 0);
        CS = 1'b0; Read = 1'b0; STRB = 4'h0;
        @(negedge mclock);
        mreset = 1'b0;
        do_rd("rst2_disp", 8'h81, 8'd100);
        do_rd("rst2_blank", 8'h82, 8'd10);
        do_rd("rst2_bright", 8'h83, 8'hFF);
        do_rd("rst2_ctrl", 8'h80, 8'h01);
        do_rd("rst2_back0", 8'h00, 8'h00);
        bus(1'b1, 1'b0, 8'h83, 8'h12, 4'h0, d, a, a2);
        check_val("strb0_ack", a, 1);
        do_rd("strb0_bright", 8'h83, 8'hFF);
        do_rd("unmapped90", 8'h90, 8'h00);
        bus(1'b1, 1'b1, 8'h83, 8'h77, 4'h1, d, a, a2);
        check_val("wr_rd_ack", a, 1);
        check_val("wr_rd_dout", d, 8'h00);
        do_rd("wr_rd_bright", 8'h83, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dotmatrix_scan_ctrl.md
Name: dotmatrix_scan_ctrl

Overview:
Parametrised, double-buffered LED dot-matrix scan controller on the peripheral bus (CS/Write/Read/Address/Data_i/STRB/Data_o/ack). It generalises the 8x8 scanner with:
- ROWS/COLS parameters
- software-programmable display and blank times
- global PWM brightness
- front/back frame buffers swapped atomically at frame end
- run-enable control and a frame_sync pulse
It drives Row/Col pins directly.

Parameters:
ROWS, 8, number of scanned rows (2..16)
COLS, 8, columns per row (1..8; one bus byte per row)
TICK_DIV, 2500, mclock cycles per scan tick (100 us at 25 MHz); tick period is exactly TICK_DIV cycles
DISP_RST, 100, reset value of DISP_TIME register (ticks)
BLANK_RST, 10, reset value of BLANK_TIME register (ticks)

Ports:
mclock  in  1  clock
mreset  in  1  reset, asynchronous, active-high
CS  in  1  chip select
Write  in  1  write strobe (qualified by CS)
Read  in  1  read strobe (qualified by CS)
Address  in  8  register/buffer address
Data_i  in  8  write data
STRB  in  4  byte strobes; only STRB[0] is used, and writes require it
Data_o  out  8  registered read data
ack  out  1  one-cycle bus acknowledge
Row  out  ROWS  one-hot active row
Col  out  COLS  column data for the active row
frame_sync  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async; all values below apply immediately):
  - Data_o=0, ack=0, frame_sync=0.
  - Both buffers all-zero; DISP_TIME=DISP_RST, BLANK_TIME=BLANK_RST, BRIGHT=8'hFF, EN=1.
  - swap_pending=0, row=0, tick counter=0, pwm_cnt=0, state=BLANK.
- Address map:
  - 0x00..ROWS-1: back buffer row (R/W).
  - 0x80 CTRL: bit0 EN (R/W); bit1 SWAP, write-1 sets swap_pending, reads as swap_pending.
  - 0x81 DISP_TIME; 0x82 BLANK_TIME; 0x83 BRIGHT.
  - 0x84 STATUS (RO): [3:0]=current row, bit4=state==DISP.
  - Other addresses read 0; writes to them are ignored.
- Bus handshake:
  - Cycle N with CS & (Write|Read) → ack=1 in cycle N+1 only. Every access is acked, including unmapped ones.
  - Write takes effect in N+1 only when STRB[0]=1.
  - Write and Read both asserted: the access is a write, and Data_o=0.
  - Read: Data_o=value in N+1. Data_o=0 whenever ack=0.
  - Writing SWAP=1 while swap_pending=1 has no further effect.
- Tick: counter runs 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1.
- pwm_cnt: 8-bit free-running, increments every mclock.
- FSM states, evaluated on tick where noted:
  - IDLE: entered one cycle after EN=0 from any state. Row=0, Col=0, row=0, swap_pending is retained. Leaves to BLANK the cycle after EN=1.
  - BLANK: Row/Col=0. Counts ticks; after BLANK_TIME ticks → DISP with wait counter cleared. BLANK_TIME=0 → DISP next cycle.
  - DISP: Row = 1<<row. Col = front[row] when pwm_cnt < BRIGHT, else 0; BRIGHT=0 gives dark. After max(DISP_TIME,1) ticks → NEXT.
  - NEXT (1 cycle): Row/Col=0.
    - row==ROWS-1: row=0, frame_sync=1. If swap_pending, front/back identity flips and swap_pending clears.
    - Otherwise row+1.
    - Then → BLANK.
- Swap is atomic: no displayed frame ever mixes buffers. After a swap the new back buffer is the previous front buffer, with its contents unchanged.
- Register writes to DISP_TIME/BLANK_TIME take effect at the next state entry. Writes never disturb the current count.
- Row and Col are combinational decodes of registered state/row/pwm_cnt only, with no path from bus inputs.

Decomposition:
- Package dotmatrix_pkg: address constants (ADDR_CTRL, ADDR_DISP, ADDR_BLANK, ADDR_BRIGHT, ADDR_STATUS), CTRL bit indices, and the FSM state enum (IDLE, BLANK, DISP, NEXT).
- Sub-module dotmatrix_tick_gen: parametrised TICK_DIV divider emitting the single-cycle tick with async reset. Reused by future display blocks.

Test Plan:
1. Reset, TICK_DIV=4, defaults:
   - Read 0x81 → ack one cycle later with Data_o=100.
   - Read 0x82 → 10.
   - Read 0x83 → 0xFF.
   - Row=0 for the first 40 cycles (10 blank ticks), then Row=8'h01.
2. Write 0x00=0xA5 with no SWAP:
   - Col stays 0 in every DISP of row 0.
   - Write CTRL=0x03: swap takes effect at the next frame_sync.
   - Then row 0 shows Col=0xA5 (BRIGHT=0xFF), and reading 0x00 returns 0 (old front).
3. BRIGHT=0x40, front row 0=0xFF: during DISP, Col=0xFF for exactly 64 of every 256 cycles.
4. BLANK_TIME=0, DISP_TIME=0, ROWS=8:
   - Row sequence 01,02,…,80,01 with one DISP tick each.
   - frame_sync pulses once per 8 rows.
5. CTRL=0x00 mid-DISP on row 3: next cycle Row=0, Col=0, STATUS[3:0]=0. CTRL=0x01 resumes from BLANK on row 0.
6. Assert mreset mid-DISP, asynchronously between clock edges: Row/Col/ack/Data_o/frame_sync go to 0 immediately, and all registers return to reset values. Separately, a write with STRB=0 is acked but changes nothing, and a read of 0x90 returns 0 with ack.
